// File: rtl/g_macro_pkg.sv
// g_macro_pkg: shared mode constants and width helper for the clocked macro library
package g_macro_pkg;
  localparam int G_MODE_LEVEL = 0;
  localparam int G_MODE_PULSE = 1;
  localparam int G_MODE_STICKY = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/g_qual_cnt.sv
// g_qual_cnt: saturating count of consecutive enabled true samples, flags reaching QUAL
module g_qual_cnt
  import g_macro_pkg::*;
#(
  parameter int QUAL = 1
) (
  input  logic CK,
  input  logic RN,
  input  logic EN,
  input  logic T,
  output logic Q_NEXT,
  output logic Q
);
  localparam int W = clog2(QUAL + 1);
  localparam logic [W-1:0] QMAX = W'(QUAL);
  logic [W-1:0] cnt, cnt_next;
  always_comb begin
    cnt_next = !EN ? cnt : !T ? '0 : (cnt == QMAX) ? cnt : cnt + W'(1);
    Q_NEXT = (cnt_next == QMAX);
  end
  always_ff @(posedge CK) begin
    if (!RN) begin
      cnt <= '0;
      Q <= 1'b0;
    end else begin
      cnt <= cnt_next;
      Q <= Q_NEXT;
    end
  end
endmodule

// File: rtl/g_andn_qual.sv
// g_andn_qual: registered, qualified mixed-polarity AND decode with level, pulse or sticky output
module g_andn_qual
  import g_macro_pkg::*;
#(
  parameter int N = 4,
  parameter logic [N-1:0] INV_MASK = N'(4'b1110),
  parameter int QUAL = 1,
  parameter int MODE = G_MODE_LEVEL
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         EN,
  input  logic         CLR,
  input  logic [N-1:0] A,
  output logic         Y,
  output logic         Q,
  output logic         P
);
  if (N < 2 || N > 32) begin : g_bad_n
    $error("g_andn_qual: N must be 2..32");
  end
  if (QUAL < 1 || QUAL > 255) begin : g_bad_qual
    $error("g_andn_qual: QUAL must be 1..255");
  end
  if (MODE < G_MODE_LEVEL || MODE > G_MODE_STICKY) begin : g_bad_mode
    $error("g_andn_qual: MODE must be 0..2");
  end
  logic term, q_next, p_next, sticky, s_next;
  assign term = &(A ^ INV_MASK);
  g_qual_cnt #(.QUAL(QUAL)) u_cnt (
    .CK(CK),
    .RN(RN),
    .EN(EN),
    .T(term),
    .Q_NEXT(q_next),
    .Q(Q)
  );
  // set wins over a same-cycle clear so no qualified event is lost
  always_comb begin
    p_next = EN & q_next & ~Q;
    s_next = p_next | (sticky & ~CLR);
  end
  always_ff @(posedge CK) begin
    if (!RN) begin
      P <= 1'b0;
      sticky <= 1'b0;
    end else begin
      P <= p_next;
      sticky <= s_next;
    end
  end
  assign Y = (MODE == G_MODE_PULSE) ? P : (MODE == G_MODE_STICKY) ? sticky : Q;
endmodule

// File: tb/tb_g_andn_qual.sv
// tb_g_andn_qual: four configurations driven by directed then random stimulus against a run-length model
module tb_g_andn_qual;
  localparam int QL[4] = '{1, 3, 3, 255};
  localparam int MD[4] = '{0, 1, 2, 0};
  localparam int NW[4] = '{4, 4, 4, 8};
  localparam logic [7:0] MK[4] = '{8'h0E, 8'h0E, 8'h0E, 8'hA5};
  logic clk = 1'b0;
  logic rn[4], en[4], clr[4];
  logic [7:0] a[4];
  logic y[4], q[4], p[4];
  int run[4];
  logic mq[4], mp[4], ms[4];
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  g_andn_qual u0 (.CK(clk), .RN(rn[0]), .EN(en[0]), .CLR(clr[0]), .A(a[0][3:0]), .Y(y[0]), .Q(q[0]), .P(p[0]));
  g_andn_qual #(.QUAL(3), .MODE(1)) u1 (.CK(clk), .RN(rn[1]), .EN(en[1]), .CLR(clr[1]), .A(a[1][3:0]), .Y(y[1]), .Q(q[1]), .P(p[1]));
  g_andn_qual #(.QUAL(3), .MODE(2)) u2 (.CK(clk), .RN(rn[2]), .EN(en[2]), .CLR(clr[2]), .A(a[2][3:0]), .Y(y[2]), .Q(q[2]), .P(p[2]));
  g_andn_qual #(.N(8), .INV_MASK(8'hA5), .QUAL(255), .MODE(0)) u3 (.CK(clk), .RN(rn[3]), .EN(en[3]), .CLR(clr[3]), .A(a[3]), .Y(y[3]), .Q(q[3]), .P(p[3]));
  // the term holds only for the single pattern that is the complement of the mask
  function automatic logic term(int i);
    for (int j = 0; j < NW[i]; j++) if (a[i][j] == MK[i][j]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic drive_t(int i, bit v);
    if (v) a[i] = ~MK[i];
    else begin
      a[i] = 8'($urandom);
      if (term(i)) a[i][0] = ~a[i][0];
    end
  endtask
  task automatic chk(string tag, int got, int exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      logic t, nq;
      t = term(i);
      if (!rn[i]) begin
        run[i] = 0; mq[i] = 0; mp[i] = 0; ms[i] = 0;
      end else if (en[i]) begin
        run[i] = t ? run[i] + 1 : 0;
        nq = (run[i] >= QL[i]);
        mp[i] = nq & !mq[i];
        mq[i] = nq;
        ms[i] = mp[i] | (ms[i] & !clr[i]);
      end else begin
        mp[i] = 0;
        ms[i] = ms[i] & !clr[i];
      end
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      logic ey;
      ey = (MD[i] == 1) ? mp[i] : (MD[i] == 2) ? ms[i] : mq[i];
      chk($sformatf("y%0d", i), int'(y[i]), int'(ey));
      chk($sformatf("q%0d", i), int'(q[i]), int'(mq[i]));
      chk($sformatf("p%0d", i), int'(p[i]), int'(mp[i]));
    end
  endtask
  initial begin
    int np;
    for (int i = 0; i < 4; i++) begin
      rn[i] = 0; en[i] = 1; clr[i] = 0; run[i] = 0;
      drive_t(i, 0);
    end
    tick(); tick();
    for (int i = 0; i < 4; i++) rn[i] = 1;
    a[0] = 8'h01; tick();
    chk("d_q_rise", int'(q[0]), 1); chk("d_y_rise", int'(y[0]), 1); chk("d_p_rise", int'(p[0]), 1);
    tick();
    chk("d_p_once", int'(p[0]), 0); chk("d_q_hold", int'(q[0]), 1);
    a[0] = 8'h03; tick();
    chk("d_q_fall", int'(q[0]), 0); chk("d_y_fall", int'(y[0]), 0);
    for (int k = 0; k < 2; k++) begin drive_t(1, 1); tick(); chk("pl_run1", int'(y[1]), 0); end
    drive_t(1, 0); tick(); chk("pl_gap", int'(y[1]), 0);
    for (int k = 0; k < 5; k++) begin
      drive_t(1, 1); tick();
      chk($sformatf("pl_run2_%0d", k), int'(p[1]), int'(k == 2));
      chk($sformatf("pl_y_%0d", k), int'(y[1]), int'(k == 2));
    end
    drive_t(2, 0); tick();
    for (int k = 0; k < 2; k++) begin drive_t(2, 1); tick(); chk("en_pre", int'(q[2]), 0); end
    en[2] = 0;
    for (int k = 0; k < 4; k++) begin drive_t(2, k[0]); tick(); chk("en_gap_p", int'(p[2]), 0); chk("en_gap_q", int'(q[2]), 0); end
    en[2] = 1; drive_t(2, 1); tick();
    chk("en_q_rise", int'(q[2]), 1); chk("en_p_rise", int'(p[2]), 1);
    for (int k = 0; k < 3; k++) begin drive_t(2, 0); tick(); chk("st_hold", int'(y[2]), 1); end
    clr[2] = 1; tick(); chk("st_clr", int'(y[2]), 0); clr[2] = 0;
    for (int k = 0; k < 2; k++) begin drive_t(2, 1); tick(); chk("st_idle", int'(y[2]), 0); end
    clr[2] = 1; tick(); chk("st_set_wins", int'(y[2]), 1); chk("st_set_p", int'(p[2]), 1); clr[2] = 0;
    drive_t(2, 0); tick();
    for (int k = 0; k < 2; k++) begin drive_t(2, 1); tick(); end
    chk("rs_pre_s", int'(y[2]), 1);
    rn[2] = 0; tick();
    chk("rs_y", int'(y[2]), 0); chk("rs_q", int'(q[2]), 0); chk("rs_p", int'(p[2]), 0);
    rn[2] = 1;
    for (int k = 0; k < 3; k++) begin tick(); chk($sformatf("rs_requal_%0d", k), int'(q[2]), int'(k == 2)); end
    drive_t(3, 1); np = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      chk($sformatf("w_q_%0d", k), int'(q[3]), int'(k >= 254));
      np += int'(p[3]);
    end
    chk("w_one_pulse", np, 1);
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        rn[i] = ($urandom_range(0, 49) != 0);
        en[i] = ($urandom_range(0, 4) != 0);
        clr[i] = ($urandom_range(0, 9) == 0);
        drive_t(i, $urandom_range(0, 2) != 0);
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
